// File: rtl/guess_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : guess_ctrl
//  Description : Sequencer for the 4-digit guessing game. Collects the
//                setter's digits for the target generator, latches the
//                target, then scores player guesses as A (right digit, right
//                place) and B (right digit, wrong place), counts attempts
//                and declares win or lose.
//  Options     : GUESS_TIMEOUT_EN - an idle PLAY phase of TIMEOUT_CYC cycles
//                is scored as a miss.
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_ctrl #(
    parameter int MAX_TRIES   = 8,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    input  logic       key_enter,
    input  logic       key_clr,
    output logic [3:0] s3,
    output logic [3:0] s2,
    output logic [3:0] s1,
    output logic [3:0] s0,
    input  logic [3:0] g3,
    input  logic [3:0] g2,
    input  logic [3:0] g1,
    input  logic [3:0] g0,
    output logic [3:0] t3,
    output logic [3:0] t2,
    output logic [3:0] t1,
    output logic [3:0] t0,
    output logic [3:0] b3,
    output logic [3:0] b2,
    output logic [3:0] b1,
    output logic [3:0] b0,
    output logic [2:0] a_cnt,
    output logic [2:0] b_cnt,
    output logic [3:0] tries,
    output logic       res_valid,
    output logic       win,
    output logic       lose,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET    = 3'd1,
        ST_GEN    = 3'd2,
        ST_PLAY   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_RESULT = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t      state_q;
    logic [15:0] buf_q, buf_d;      // digit buffer, b3 in the top nibble
    logic [2:0]  dcnt_q, dcnt_d;
    logic [15:0] s_hold_q;          // setter digits captured on the last SET cycle
    logic [15:0] t_q;
    logic [15:0] guess_q;
    logic [1:0]  idx_q;
    logic [2:0]  acc_a_q, acc_b_q;
    logic [2:0]  a_cnt_q, b_cnt_q;
    logic [3:0]  tries_q;
    logic        res_valid_q, win_q, lose_q, busy_q;

    logic [3:0]  w_g_digit, w_t_digit;
    logic        w_hit_a, w_hit_b;
    logic [3:0]  w_tries_inc;
    logic        w_timeout_hit;

    // Key handling for the digit buffer: clear beats shift, and a shift is
    // dropped when enter arrives in the same cycle so enter sees the old buffer.
    always_comb begin
        buf_d  = buf_q;
        dcnt_d = dcnt_q;
        if (key_clr) begin
            buf_d  = '0;
            dcnt_d = '0;
        end else if (key_valid && !key_enter && (dcnt_q < 3'd4)) begin
            buf_d  = {buf_q[11:0], key_val};
            dcnt_d = dcnt_q + 3'd1;
        end
    end

    // Score the guess digit at position idx against the whole target.
    always_comb begin
        w_g_digit = guess_q[{idx_q, 2'b00} +: 4];
        w_t_digit = t_q[{idx_q, 2'b00} +: 4];
        w_hit_a   = (w_g_digit == w_t_digit);
        w_hit_b   = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if ((2'(j) != idx_q) && (t_q[j*4 +: 4] == w_g_digit)) begin
                w_hit_b = 1'b1;
            end
        end
    end

    assign w_tries_inc = (tries_q == 4'd15) ? 4'd15 : (tries_q + 4'd1);

`ifdef GUESS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            w_any_key;

    assign w_any_key     = key_valid | key_enter | key_clr;
    assign w_timeout_hit = (state_q == ST_PLAY) && !w_any_key &&
                           (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // Idle counter: runs only while in PLAY, restarts on any key activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if ((state_q != ST_PLAY) || w_any_key) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    // No timeout: a constant-false hit leaves PLAY waiting indefinitely.
    assign w_timeout_hit = (TIMEOUT_CYC < 0);
`endif

    // Game sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            dcnt_q      <= '0;
            s_hold_q    <= '0;
            t_q         <= '0;
            guess_q     <= '0;
            idx_q       <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            tries_q     <= '0;
            res_valid_q <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SET;
                        buf_q   <= '0;
                        dcnt_q  <= '0;
                    end
                end
                ST_SET: begin
                    s_hold_q <= buf_q;
                    if (key_enter) begin
                        state_q <= ST_GEN;
                        busy_q  <= 1'b1;
                    end else begin
                        buf_q  <= buf_d;
                        dcnt_q <= dcnt_d;
                    end
                end
                ST_GEN: begin
                    t_q     <= {g3, g2, g1, g0};
                    tries_q <= '0;
                    a_cnt_q <= '0;
                    b_cnt_q <= '0;
                    win_q   <= 1'b0;
                    lose_q  <= 1'b0;
                    buf_q   <= '0;
                    dcnt_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (key_enter && (dcnt_q == 3'd4)) begin
                        guess_q <= buf_q;
                        idx_q   <= '0;
                        acc_a_q <= '0;
                        acc_b_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CHECK;
                    end else if (w_timeout_hit) begin
                        acc_a_q <= '0;
                        acc_b_q <= '0;
                        state_q <= ST_RESULT;
                    end else begin
                        buf_q  <= buf_d;
                        dcnt_q <= dcnt_d;
                    end
                end
                ST_CHECK: begin
                    if (w_hit_a) begin
                        acc_a_q <= acc_a_q + 3'd1;
                    end else if (w_hit_b) begin
                        acc_b_q <= acc_b_q + 3'd1;
                    end
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    a_cnt_q     <= acc_a_q;
                    b_cnt_q     <= acc_b_q;
                    res_valid_q <= 1'b1;
                    tries_q     <= w_tries_inc;
                    if (acc_a_q == 3'd4) begin
                        win_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (w_tries_inc == 4'(MAX_TRIES)) begin
                        lose_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        buf_q   <= '0;
                        dcnt_q  <= '0;
                        state_q <= ST_PLAY;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_q <= ST_SET;
                        buf_q   <= '0;
                        dcnt_q  <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The generator follows the live buffer while setting, then the held value.
    assign {s3, s2, s1, s0} = (state_q == ST_SET) ? buf_q : s_hold_q;
    assign {t3, t2, t1, t0} = t_q;
    assign {b3, b2, b1, b0} = buf_q;
    assign a_cnt            = a_cnt_q;
    assign b_cnt            = b_cnt_q;
    assign tries            = tries_q;
    assign res_valid        = res_valid_q;
    assign win              = win_q;
    assign lose             = lose_q;
    assign busy             = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_guess_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_guess_ctrl
//  Description : Scoreboard bench for guess_ctrl (MAX_TRIES=3, TIMEOUT_CYC=10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, key_valid, key_enter, key_clr, gen_rand;
    logic [3:0] key_val;
    logic [3:0] s3, s2, s1, s0, g3, g2, g1, g0;
    logic [3:0] t3, t2, t1, t0, b3, b2, b1, b0;
    logic [2:0] a_cnt, b_cnt;
    logic [3:0] tries;
    logic       res_valid, win, lose, busy;

    always #5 clk = ~clk;

    // Generator model: pass setter digits through, or force A735.
    assign g3 = gen_rand ? 4'hA : s3;
    assign g2 = gen_rand ? 4'h7 : s2;
    assign g1 = gen_rand ? 4'h3 : s1;
    assign g0 = gen_rand ? 4'h5 : s0;

    guess_ctrl #(.MAX_TRIES(3), .TIMEOUT_CYC(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
        .key_val(key_val), .key_enter(key_enter), .key_clr(key_clr),
        .s3(s3), .s2(s2), .s1(s1), .s0(s0),
        .g3(g3), .g2(g2), .g1(g1), .g0(g0),
        .t3(t3), .t2(t2), .t1(t1), .t0(t0),
        .b3(b3), .b2(b2), .b1(b1), .b0(b0),
        .a_cnt(a_cnt), .b_cnt(b_cnt), .tries(tries), .res_valid(res_valid),
        .win(win), .lose(lose), .busy(busy)
    );

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] tr;
        logic       w;
        logic       l;
        int         cyc;
        logic       chk_lat;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (res_valid) begin
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_res_valid: got res_valid=1 at cycle %0d, required none", cyc);
            end else begin
                e = sbq.pop_front();
                cmp("a_cnt", int'(a_cnt), int'(e.a));
                cmp("b_cnt", int'(b_cnt), int'(e.b));
                cmp("tries", int'(tries), int'(e.tr));
                cmp("win",   int'(win),   int'(e.w));
                cmp("lose",  int'(lose),  int'(e.l));
                if (e.chk_lat) cmp("res_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] v);
        key_val   = v;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic type4(input logic [15:0] d);
        for (int i = 3; i >= 0; i--) press(d[i*4 +: 4]);
    endtask

    task automatic enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clr();
        key_clr = 1'b1;
        tick();
        key_clr = 1'b0;
    endtask

    // Called in the cycle the enter pulse is driven; result due 6 cycles later.
    task automatic push(input int a, input int b, input int tr, input int w,
                        input int l, input int lat);
        exp_t x;
        x.a       = 3'(a);
        x.b       = 3'(b);
        x.tr      = 4'(tr);
        x.w       = 1'(w);
        x.l       = 1'(l);
        x.cyc     = cyc + 6;
        x.chk_lat = 1'(lat);
        sbq.push_back(x);
    endtask

    task automatic wait_sb(input int maxc);
        int n = 0;
        while (sbq.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL result_timeout: got %0d pending results after %0d cycles, required 0", sbq.size(), maxc);
            sbq.delete();
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; key_valid = 1'b0; key_enter = 1'b0;
        key_clr = 1'b0; key_val = 4'h0; gen_rand = 1'b0;
        idle(3);
        cmp("rst_scores", int'({a_cnt, b_cnt, tries}), 0);
        cmp("rst_flags",  int'({res_valid, win, lose, busy}), 0);
        cmp("rst_digits", int'({t3, t2, t1, t0, b3, b2, b1, b0}), 0);
        cmp("rst_setter", int'({s3, s2, s1, s0}), 0);
        rst = 1'b1;
        tick();

        // Set 1234, immediate win.
        pulse_start();
        type4(16'h1234);
        cmp("set_s_follows_buf", int'({s3, s2, s1, s0}), 'h1234);
        cmp("set_buf", int'({b3, b2, b1, b0}), 'h1234);
        enter();
        cmp("gen_busy", int'(busy), 1);
        tick();
        cmp("target_1234", int'({t3, t2, t1, t0}), 'h1234);
        cmp("play_busy", int'(busy), 0);
        cmp("play_buf_cleared", int'({b3, b2, b1, b0}), 0);
        type4(16'h1234);
        push(4, 0, 1, 1, 0, 1);
        enter();
        wait_sb(20);
        press(4'h5);
        cmp("done_keys_dropped", int'({b3, b2, b1, b0}), 'h1234);
        enter();
        idle(8);
        cmp("done_win_held", int'(win), 1);

        // New game on 1234: 4321, 1243, then win on the last allowed try.
        pulse_start();
        cmp("set_win_held", int'(win), 1);
        cmp("set_buf_cleared", int'({b3, b2, b1, b0}), 0);
        type4(16'h1234);
        enter();
        tick();
        cmp("gen_clears_flags", int'({win, lose, tries}), 0);
        type4(16'h4321);
        push(0, 4, 1, 0, 0, 1);
        enter();
        wait_sb(20);
        type4(16'h1243);
        push(2, 2, 2, 0, 0, 1);
        enter();
        wait_sb(20);
        type4(16'h1234);
        push(4, 0, 3, 1, 0, 1);
        enter();
        wait_sb(20);

        // Empty setter: generator supplies A735; duplicates; lose on try 3.
        pulse_start();
        cmp("empty_set_s", int'({s3, s2, s1, s0}), 0);
        gen_rand = 1'b1;
        enter();
        tick();
        gen_rand = 1'b0;
        cmp("target_A735", int'({t3, t2, t1, t0}), 'hA735);
        press(4'h5);
        pulse_start();
        press(4'h6); press(4'h7); press(4'h8);
        cmp("play_start_ignored", int'({b3, b2, b1, b0}), 'h5678);
        push(0, 2, 1, 0, 0, 1);
        enter();
        wait_sb(20);
        type4(16'h5555);
        push(1, 3, 2, 0, 0, 1);
        enter();
        wait_sb(20);
        type4(16'h7A53);
        push(0, 4, 3, 0, 1, 1);
        enter();
        wait_sb(20);
        enter();
        idle(8);
        pulse_start();
        cmp("set_lose_held", int'(lose), 1);
        cmp("set_not_busy", int'(busy), 0);

        // Buffer rules in PLAY on target 1234.
        type4(16'h1234);
        enter();
        tick();
        cmp("gen_clears_lose", int'(lose), 0);
        press(4'h1); press(4'h2); press(4'h3);
        enter();
        idle(4);
        press(4'h4);
        press(4'h9);
        cmp("fifth_digit_ignored", int'({b3, b2, b1, b0}), 'h1234);
        clr();
        cmp("clr_buf", int'({b3, b2, b1, b0}), 0);
        press(4'h1); press(4'h2); press(4'h3); press(4'h5);
        push(3, 0, 1, 0, 0, 1);
        key_val   = 4'h9;
        key_valid = 1'b1;
        key_enter = 1'b1;
        tick();
        key_valid = 1'b0;
        key_enter = 1'b0;
        wait_sb(20);
        cmp("result_clears_buf", int'({b3, b2, b1, b0}), 0);

        // Reset in the second CHECK cycle aborts the check.
        type4(16'h2143);
        enter();
        tick();
        rst = 1'b0;
        #1;
        cmp("abort_scores", int'({a_cnt, b_cnt, tries}), 0);
        cmp("abort_flags", int'({res_valid, win, lose, busy}), 0);
        cmp("abort_digits", int'({t3, t2, t1, t0, b3, b2, b1, b0}), 0);
        idle(2);
        rst = 1'b1;
        idle(8);
        cmp("abort_tries", int'(tries), 0);
        pulse_start();
        press(4'h7);
        cmp("after_abort_set", int'({s3, s2, s1, s0}), 'h0007);

`ifdef GUESS_TIMEOUT_EN
        // Idle in PLAY is scored as a miss.
        press(4'h1); press(4'h2); press(4'h3);
        enter();
        tick();
        push(0, 0, 1, 0, 0, 0);
        wait_sb(40);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/guess_ctrl.md
Name: guess_ctrl

Overview:
- Game sequencer for the 4-digit guessing game. Collects the setter's digits and hands them to the target generator.
- Latches the completed target, then collects player guesses and scores each one as A (right digit, right place) and B (right digit, wrong place).
- Counts attempts and declares win or lose. Sits between the keypad decoder and the display driver, and owns the generator's inputs.

Parameters:
- MAX_TRIES, 8, guesses allowed per game (1..15).
- TIMEOUT_CYC, 50000000, idle cycles in PLAY before a forced miss (only with GUESS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- start  in  1  one-cycle pulse; begins a new game from IDLE or DONE
- key_valid  in  1  one-cycle pulse; key_val holds a digit
- key_val  in  4  digit value
- key_enter  in  1  one-cycle pulse; commit the digit buffer
- key_clr  in  1  one-cycle pulse; clear the digit buffer
- s3,s2,s1,s0  out  4 each  setter digits driven to the generator (0 = "fill randomly")
- g3,g2,g1,g0  in  4 each  generator outputs (combinational from s*)
- t3,t2,t1,t0  out  4 each  latched target
- b3,b2,b1,b0  out  4 each  live digit buffer, for display
- a_cnt  out  3  A score of the last guess
- b_cnt  out  3  B score of the last guess
- tries  out  4  guesses scored so far in this game
- res_valid  out  1  one-cycle pulse when a_cnt/b_cnt update
- win  out  1  level, game won
- lose  out  1  level, game lost
- busy  out  1  high in GEN and CHECK

Behaviour:
- Reset (rst=0, async): state=IDLE. All digit registers, t*, s*, a_cnt, b_cnt, tries, idx and dcnt = 0. res_valid, win, lose, busy = 0.
- Digit buffer {b3,b2,b1,b0} with entry count dcnt (0..4):
  - key_valid with dcnt<4 shifts left: {b2,b1,b0,key_val}, dcnt+1.
  - key_valid with dcnt==4 is ignored.
  - key_clr zeroes the buffer and dcnt; it wins over key_valid in the same cycle.
  - The buffer is active only in SET and PLAY.
- s* = buffer while in SET; otherwise s* holds its last SET value.
- States:
  - IDLE: start -> SET; clear buffer.
  - SET:
    - key_enter -> GEN at any dcnt; unentered digits stay 0 and are randomised by the generator.
    - start is ignored.
  - GEN (1 cycle):
    - t* <= g*; tries <= 0; a_cnt/b_cnt <= 0; win/lose <= 0; clear buffer.
    - -> PLAY.
  - PLAY:
    - key_enter with dcnt==4 -> CHECK; latch the buffer as the guess; idx <= 0; clear the A/B accumulators.
    - key_enter with dcnt<4 is ignored.
  - CHECK (exactly 4 cycles, idx=0..3, position idx is scored):
    - A += 1 if guess[idx]==t[idx].
    - Else B += 1 if guess[idx]==t[j] for any j!=idx.
    - Duplicates are not de-duplicated: each guess position contributes at most 1 to A or B.
    - After idx=3 -> RESULT.
  - RESULT (1 cycle):
    - a_cnt/b_cnt <= accumulators; res_valid=1; tries <= tries+1 (saturating at 15).
    - If A==4 -> DONE, win<=1.
    - Else if tries+1==MAX_TRIES -> DONE, lose<=1.
    - Else -> PLAY with the buffer cleared.
  - DONE: hold all outputs; start -> SET (clears win/lose on GEN entry).
- Latency: key_enter accepted in PLAY at cycle t -> res_valid at cycle t+6 (1 cycle into CHECK, 4 CHECK cycles, 1 RESULT).
- Keys during GEN/CHECK/RESULT/DONE are dropped.
- start outside IDLE/DONE is ignored.
- Simultaneous key_enter and key_valid: key_enter uses the pre-shift buffer; key_valid is dropped.
- Asserting rst mid-CHECK aborts the check: no res_valid, tries unchanged at 0 after reset, state IDLE.

Optional Feature:
- GUESS_TIMEOUT_EN defined:
  - A counter runs only in PLAY and clears on any key pulse or on PLAY entry.
  - When it reaches TIMEOUT_CYC-1, go to RESULT with A=B=0, which counts as a scored miss (res_valid pulses, tries+1, may produce lose).
- Undefined: no counter; PLAY waits indefinitely; TIMEOUT_CYC unused.

Test Plan:
- Set 1,2,3,4, enter (bench g*=s*) -> t=1234; guess 1234 -> res_valid 6 cycles after enter, a_cnt=4, b_cnt=0, win=1, tries=1.
- Target 1234, guess 4321 -> a=0, b=4, PLAY again. Guess 1243 -> a=2, b=2, tries=2.
- Set with no digits, enter; bench drives g*=A,7,3,5 -> t=A735; s*=0000 observed during SET.
- MAX_TRIES=3, target 1234, guesses 5678 x3 -> third RESULT gives lose=1, state DONE; further key_enter ignored; start -> SET.
- Guess enter with only 3 digits -> no transition. Fifth key_valid ignored. key_clr then 4 digits -> accepted.
- rst low at the 2nd CHECK cycle -> all outputs 0 immediately, no res_valid. With GUESS_TIMEOUT_EN and TIMEOUT_CYC=10, idle in PLAY -> res_valid with a=0, b=0, tries+1.
